// File: rtl/beta_fetch.sv
// Beta pipeline instruction-fetch stage: owns the PC, addresses the
// instruction memory, and loads the IF/RF instruction register. Handles
// next-PC selection, supervisor-bit protection, and interrupt entry.
// Wrong-path fetches are annulled by loading a NOP.
module beta_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h8000_0000,
    parameter logic [31:0] ILLOP_PC  = 32'h8000_0004,
    parameter logic [31:0] XADR_PC   = 32'h8000_0008,
    parameter logic [31:0] NOP_INSTR = 32'hC3FF_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic [2:0]  pcsel,
    input  logic [31:0] branch_target,
    input  logic [31:0] jmp_target,
    input  logic        irq,
    input  logic [31:0] id,
    output logic [31:0] ia,
    output logic [31:0] ir,
    output logic [31:0] ir_pc4,
    output logic        ir_valid,
    output logic        irq_ack,
    output logic [31:0] xp_value
);

    typedef enum logic [2:0] {
        SEL_SEQ   = 3'd0,
        SEL_BR    = 3'd1,
        SEL_JMP   = 3'd2,
        SEL_ILLOP = 3'd3,
        SEL_XADR  = 3'd4
    } pcsel_e;

    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] next_pc;
    logic        redirect;
    logic        take_irq;

    // Target bit 31 of a branch and the byte offset of any target are
    // discarded; the supervisor bit comes from the current PC instead.
    logic unused_target_bits;
    assign unused_target_bits = ^{branch_target[31], branch_target[1:0], jmp_target[1:0]};

    // Next-PC selection; pcsel codes 5-7 fall through to sequential.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        pc4      = {pc[31], pc[30:0] + 31'd4};
        next_pc  = pc4;
        redirect = 1'b1;
        case (pcsel)
            SEL_BR:    next_pc = {pc[31], branch_target[30:2], 2'b00};
            SEL_JMP:   next_pc = {pc[31] & jmp_target[31], jmp_target[30:2], 2'b00};
            SEL_ILLOP: next_pc = ILLOP_PC;
            SEL_XADR:  next_pc = XADR_PC;
            default:   redirect = 1'b0;
        endcase
        // Interrupts only in user mode and only on an otherwise sequential cycle.
        take_irq = irq & ~pc[31] & ~stall & ~redirect;
        if (take_irq) begin
            next_pc = XADR_PC;
        end
    end

    // PC and IF/RF register update; stall freezes everything.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!reset_n) begin
            pc       <= RESET_PC;
            ir       <= NOP_INSTR;
            ir_pc4   <= RESET_PC + 32'd4;
            ir_valid <= 1'b0;
        end else if (!stall) begin
            pc     <= next_pc;
            ir_pc4 <= pc4;
            if (redirect || take_irq) begin
                ir       <= NOP_INSTR;
                ir_valid <= 1'b0;
            end else begin
                ir       <= id;
                ir_valid <= 1'b1;
            end
        end
    end

    assign ia       = pc;
    assign irq_ack  = take_irq;
    assign xp_value = take_irq ? pc4 : 32'd0;

endmodule

// File: tb/tb_beta_fetch.sv
// Self-checking bench for beta_fetch: directed vectors, a behavioural
// model compared every cycle, plus hand-computed literal expectations.
module tb_beta_fetch;

    localparam logic [31:0] NOP = 32'hC3FF_0000;
    localparam logic [31:0] K   = 32'h5A5A_0001;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall;
    logic [2:0]  pcsel;
    logic [31:0] branch_target;
    logic [31:0] jmp_target;
    logic        irq;
    logic [31:0] id;
    logic [31:0] ia;
    logic [31:0] ir;
    logic [31:0] ir_pc4;
    logic        ir_valid;
    logic        irq_ack;
    logic [31:0] xp_value;

    int vectors = 0;
    int miscompares = 0;
    bit run = 1'b0;

    beta_fetch dut (
        .clk(clk), .reset_n(reset_n), .stall(stall), .pcsel(pcsel),
        .branch_target(branch_target), .jmp_target(jmp_target), .irq(irq),
        .id(id), .ia(ia), .ir(ir), .ir_pc4(ir_pc4), .ir_valid(ir_valid),
        .irq_ack(irq_ack), .xp_value(xp_value)
    );

    always #5 clk = ~clk;

    // Instruction memory: each word is a fixed scramble of its address.
    assign id = ia ^ K;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: supervisor bit and 31-bit offset held separately.
    logic        m_sup;
    logic [30:0] m_off;
    logic [31:0] m_ir;
    logic [31:0] m_ir_pc4;
    logic        m_valid;
    logic [31:0] e_ia;
    logic [31:0] e_pc4;
    int          e_sel;
    logic        e_irq;

    always_comb begin
        e_ia  = {m_sup, m_off};
        e_pc4 = {m_sup, 31'(m_off + 31'd4)};
        e_sel = (int'(pcsel) <= 4) ? int'(pcsel) : 0;
        e_irq = irq && !m_sup && !stall && (e_sel == 0);
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_sup    <= 1'b1;
            m_off    <= 31'd0;
            m_ir     <= NOP;
            m_ir_pc4 <= 32'h8000_0004;
            m_valid  <= 1'b0;
        end else if (!stall) begin
            m_ir_pc4 <= e_pc4;
            m_ir     <= NOP;
            m_valid  <= 1'b0;
            if (e_sel == 0 && !e_irq) begin
                m_off   <= e_pc4[30:0];
                m_ir    <= e_ia ^ K;
                m_valid <= 1'b1;
            end else if (e_sel == 0 || e_sel == 4) begin
                m_sup <= 1'b1;
                m_off <= 31'd8;
            end else if (e_sel == 3) begin
                m_sup <= 1'b1;
                m_off <= 31'd4;
            end else if (e_sel == 1) begin
                m_off <= {branch_target[30:2], 2'b00};
            end else begin
                m_sup <= m_sup && jmp_target[31];
                m_off <= {jmp_target[30:2], 2'b00};
            end
        end
    end

    // Compare process: all outputs against the model, mid-cycle.
    always @(negedge clk) begin
        if (run) begin
            check("m_ia", ia, e_ia);
            check("m_ir", ir, m_ir);
            check("m_ir_pc4", ir_pc4, m_ir_pc4);
            check("m_ir_valid", 32'(ir_valid), 32'(m_valid));
            check("m_irq_ack", 32'(irq_ack), 32'(e_irq));
            if (e_irq) check("m_xp_value", xp_value, e_pc4);
        end
    end

    task automatic apply(input logic [2:0] sel, input logic [31:0] bt, input logic [31:0] jt,
                         input logic st, input logic iq);
        pcsel = sel; branch_target = bt; jmp_target = jt; stall = st; irq = iq;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        apply(3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        run = 1'b1;
        tick();
        check("rst_ia", ia, 32'h8000_0000);
        check("rst_ir", ir, NOP);
        check("rst_ir_pc4", ir_pc4, 32'h8000_0004);
        check("rst_valid", 32'(ir_valid), 32'd0);
        check("rst_ack", 32'(irq_ack), 32'd0);
        check("rst_xp", xp_value, 32'd0);
        reset_n = 1'b1;

        // Sequential fetch from reset.
        tick();
        check("seq1_ia", ia, 32'h8000_0004);
        check("seq1_ir", ir, 32'h8000_0000 ^ K);
        check("seq1_valid", 32'(ir_valid), 32'd1);
        tick();
        check("seq2_ia", ia, 32'h8000_0008);
        tick();
        check("seq3_ia", ia, 32'h8000_000C);
        check("seq3_ir", ir, 32'h8000_0008 ^ K);
        tick();
        check("seq4_ia", ia, 32'h8000_0010);

        // JMP out of supervisor, then JMP cannot regain it.
        apply(3'd2, 32'd0, 32'h0000_0040, 1'b0, 1'b0); tick();
        check("jmp_user_ia", ia, 32'h0000_0040);
        check("jmp_user_ir", ir, NOP);
        check("jmp_user_valid", 32'(ir_valid), 32'd0);
        check("jmp_user_pc4", ir_pc4, 32'h8000_0014);
        apply(3'd2, 32'd0, 32'h8000_0040, 1'b0, 1'b0); tick();
        check("jmp_nosup_ia", ia, 32'h0000_0040);
        check("jmp_nosup_pc4", ir_pc4, 32'h0000_0044);

        // Branch from user mode does not gain the supervisor bit.
        apply(3'd2, 32'd0, 32'h0000_0100, 1'b0, 1'b0); tick();
        apply(3'd1, 32'h8000_0200, 32'd0, 1'b0, 1'b0); tick();
        check("br_ia", ia, 32'h0000_0200);
        check("br_ir", ir, NOP);
        check("br_valid", 32'(ir_valid), 32'd0);
        apply(3'd0, 32'd0, 32'd0, 1'b0, 1'b0); tick();
        check("br_seq_ia", ia, 32'h0000_0204);

        // Two stalled cycles with a pending branch, irq raised in the second.
        apply(3'd1, 32'h0000_0300, 32'd0, 1'b1, 1'b0); tick();
        check("stall1_ia", ia, 32'h0000_0204);
        check("stall1_ir", ir, 32'h0000_0200 ^ K);
        apply(3'd1, 32'h0000_0300, 32'd0, 1'b1, 1'b1);
        check("stall_ack", 32'(irq_ack), 32'd0);
        tick();
        check("stall2_ia", ia, 32'h0000_0204);
        check("stall2_valid", 32'(ir_valid), 32'd1);
        apply(3'd1, 32'h0000_0300, 32'd0, 1'b0, 1'b1);
        check("redir_irq_ack", 32'(irq_ack), 32'd0);
        tick();
        check("unstall_ia", ia, 32'h0000_0300);
        check("unstall_valid", 32'(ir_valid), 32'd0);

        // Interrupt at user PC 0x20, then ignored in supervisor mode.
        apply(3'd1, 32'h0000_0020, 32'd0, 1'b0, 1'b0); tick();
        apply(3'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        check("irq_ack", 32'(irq_ack), 32'd1);
        check("irq_xp", xp_value, 32'h0000_0024);
        tick();
        check("irq_ia", ia, 32'h8000_0008);
        check("irq_ir", ir, NOP);
        check("irq_valid", 32'(ir_valid), 32'd0);
        check("irq_sup_ack", 32'(irq_ack), 32'd0);
        tick();
        check("irq_sup_ia", ia, 32'h8000_000C);

        // ILLOP, XADR, supervisor JMP with truncation.
        apply(3'd3, 32'd0, 32'd0, 1'b0, 1'b0); tick();
        check("illop_ia", ia, 32'h8000_0004);
        apply(3'd4, 32'd0, 32'd0, 1'b0, 1'b0); tick();
        check("xadr_ia", ia, 32'h8000_0008);
        apply(3'd2, 32'd0, 32'h8000_0057, 1'b0, 1'b0); tick();
        check("jmp_sup_ia", ia, 32'h8000_0054);
        apply(3'd2, 32'd0, 32'h0000_0300, 1'b0, 1'b0); tick();
        check("pre_rst_ia", ia, 32'h0000_0300);

        // Asynchronous reset mid-cycle.
        #2;
        reset_n = 1'b0;
        #1;
        check("async_ia", ia, 32'h8000_0000);
        check("async_ir", ir, NOP);
        check("async_valid", 32'(ir_valid), 32'd0);
        tick();
        reset_n = 1'b1;

        // Wrap inside the low 31 bits, reserved pcsel codes, aligned branch.
        apply(3'd2, 32'd0, 32'h7FFF_FFFC, 1'b0, 1'b0); tick();
        check("wrap_pre_ia", ia, 32'h7FFF_FFFC);
        apply(3'd0, 32'd0, 32'd0, 1'b0, 1'b0); tick();
        check("wrap_ia", ia, 32'h0000_0000);
        check("wrap_pc4", ir_pc4, 32'h0000_0000);
        check("wrap_ir", ir, 32'h7FFF_FFFC ^ K);
        apply(3'd5, 32'h0000_0500, 32'd0, 1'b0, 1'b0); tick();
        check("sel5_ia", ia, 32'h0000_0004);
        check("sel5_valid", 32'(ir_valid), 32'd1);
        apply(3'd7, 32'h0000_0500, 32'd0, 1'b0, 1'b1);
        check("sel7_irq_ack", 32'(irq_ack), 32'd1);
        check("sel7_xp", xp_value, 32'h0000_0008);
        tick();
        check("sel7_irq_ia", ia, 32'h8000_0008);
        apply(3'd1, 32'h0000_0123, 32'd0, 1'b0, 1'b0); tick();
        check("br_align_ia", ia, 32'h8000_0120);

        apply(3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        tick();
        run = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
